// File: rtl/c3po_egress_buf.sv
// c3po_egress_buf: store-and-forward egress buffer; a packet is released only once its eop beat is written.
// Define C3PO_EGRESS_STATS_EN to build the saturating packet/drop/error counters; otherwise they read 0.
module c3po_egress_buf #(
  parameter int unsigned DEPTH_P    = 16,
  parameter int unsigned CNT_SIZE_P = 8
) (
  input  logic                  sig_clock,
  input  logic                  sig_reset,
  input  logic                  sig_i_sop,
  input  logic                  sig_i_eop,
  input  logic                  sig_i_val,
  input  logic [7:0]            sig_i_vbc,
  input  logic [255:0]          sig_i_data,
  output logic                  sig_buf_ready,
  output logic                  sig_d_sop,
  output logic                  sig_d_eop,
  output logic                  sig_d_val,
  output logic [7:0]            sig_d_vbc,
  output logic [255:0]          sig_d_data,
  input  logic                  sig_d_ready,
  output logic [CNT_SIZE_P-1:0] sig_pkt_cnt,
  output logic [CNT_SIZE_P-1:0] sig_drop_cnt,
  output logic [CNT_SIZE_P-1:0] sig_err_cnt
);
  localparam int unsigned AW = $clog2(DEPTH_P);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = 266;

  typedef enum logic [1:0] {IDLE, PKT, DISCARD} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          bad_q, bad_d;
  logic [EW-1:0] mem_q [DEPTH_P];
  logic [EW-1:0] d_beat_q, d_beat_d;
  logic          d_val_q, d_val_d;
  logic          full, beat_bad, store, load;
  logic [PW-1:0] waddr;
  logic          pkt_inc, drop_inc, err_inc;

  assign full     = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH_P);
  assign beat_bad = (sig_i_vbc == 8'd0) || (sig_i_vbc > 8'd32) ||
                    ((sig_i_vbc != 8'd32) && !sig_i_eop);
  // A sop always restarts at the last commit point, which also covers aborting an open packet.
  assign waddr    = sig_i_sop ? commit_ptr_q : wr_ptr_q;

  always_ff @(posedge sig_clock) begin
    if (sig_reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      bad_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      bad_q        <= bad_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    bad_d        = bad_q;
    store        = 1'b0;
    pkt_inc      = 1'b0;
    drop_inc     = 1'b0;
    err_inc      = 1'b0;
    if (sig_i_val) begin
      if (sig_i_sop) begin
        if (state_q != IDLE) err_inc = 1'b1;
        wr_ptr_d = commit_ptr_q;
        if (full) begin
          drop_inc = 1'b1;
          state_d  = sig_i_eop ? IDLE : DISCARD;
        end else begin
          store = 1'b1;
          if (!sig_i_eop) begin
            wr_ptr_d = commit_ptr_q + PW'(1);
            bad_d    = beat_bad;
            state_d  = PKT;
          end else begin
            state_d = IDLE;
            if (beat_bad) begin
              drop_inc = 1'b1;
            end else begin
              wr_ptr_d     = commit_ptr_q + PW'(1);
              commit_ptr_d = commit_ptr_q + PW'(1);
              pkt_inc      = 1'b1;
            end
          end
        end
      end else begin
        unique case (state_q)
          IDLE: err_inc = 1'b1;
          PKT: begin
            if (full) begin
              drop_inc = 1'b1;
              wr_ptr_d = commit_ptr_q;
              state_d  = sig_i_eop ? IDLE : DISCARD;
            end else begin
              store = 1'b1;
              if (!sig_i_eop) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                bad_d    = bad_q | beat_bad;
              end else begin
                state_d = IDLE;
                if (bad_q || beat_bad) begin
                  drop_inc = 1'b1;
                  wr_ptr_d = commit_ptr_q;
                end else begin
                  wr_ptr_d     = wr_ptr_q + PW'(1);
                  commit_ptr_d = wr_ptr_q + PW'(1);
                  pkt_inc      = 1'b1;
                end
              end
            end
          end
          DISCARD: if (sig_i_eop) state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    sig_buf_ready = !full || (state_q == DISCARD);
  end

  always_ff @(posedge sig_clock) begin
    if (store) mem_q[waddr[AW-1:0]] <= {sig_i_sop, sig_i_eop, sig_i_vbc, sig_i_data};
  end

  assign load = (rd_ptr_q != commit_ptr_q) && (!d_val_q || sig_d_ready);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    d_beat_d = d_beat_q;
    d_val_d  = d_val_q;
    if (load) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      d_beat_d = mem_q[rd_ptr_q[AW-1:0]];
      d_val_d  = 1'b1;
    end else if (sig_d_ready) begin
      d_val_d = 1'b0;
    end
  end

  always_ff @(posedge sig_clock) begin
    if (sig_reset) begin
      rd_ptr_q <= '0;
      d_beat_q <= '0;
      d_val_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      d_beat_q <= d_beat_d;
      d_val_q  <= d_val_d;
    end
  end

  assign {sig_d_sop, sig_d_eop, sig_d_vbc, sig_d_data} = d_beat_q;
  assign sig_d_val = d_val_q;

`ifdef C3PO_EGRESS_STATS_EN
  logic [CNT_SIZE_P-1:0] pkt_cnt_q, drop_cnt_q, err_cnt_q;

  always_ff @(posedge sig_clock) begin
    if (sig_reset) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (pkt_inc && !(&pkt_cnt_q))   pkt_cnt_q  <= pkt_cnt_q + CNT_SIZE_P'(1);
      if (drop_inc && !(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + CNT_SIZE_P'(1);
      if (err_inc && !(&err_cnt_q))   err_cnt_q  <= err_cnt_q + CNT_SIZE_P'(1);
    end
  end

  assign sig_pkt_cnt  = pkt_cnt_q;
  assign sig_drop_cnt = drop_cnt_q;
  assign sig_err_cnt  = err_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = pkt_inc ^ drop_inc ^ err_inc;
  assign sig_pkt_cnt  = '0;
  assign sig_drop_cnt = '0;
  assign sig_err_cnt  = '0;
`endif
endmodule

// File: tb/tb_c3po_egress_buf.sv
// Directed bench for c3po_egress_buf: framing, overflow, bad vbc, backpressure/wrap and reset cases.
module tb_c3po_egress_buf;
  localparam int unsigned CW = 8;
`ifdef C3PO_EGRESS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef logic [265:0] beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_sop, i_eop, i_val;
  logic [7:0]    i_vbc;
  logic [255:0]  i_data;
  logic          buf_ready;
  logic          d_sop, d_eop, d_val;
  logic [7:0]    d_vbc;
  logic [255:0]  d_data;
  logic          d_ready;
  logic [CW-1:0] pkt_cnt, drop_cnt, err_cnt;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  beat_t       rx_q[$];
  int unsigned hold_viol = 0;
  logic        prev_stall = 1'b0;
  beat_t       prev_beat;

  c3po_egress_buf #(.DEPTH_P(16), .CNT_SIZE_P(CW)) dut (
    .sig_clock(clk), .sig_reset(rst),
    .sig_i_sop(i_sop), .sig_i_eop(i_eop), .sig_i_val(i_val), .sig_i_vbc(i_vbc), .sig_i_data(i_data),
    .sig_buf_ready(buf_ready),
    .sig_d_sop(d_sop), .sig_d_eop(d_eop), .sig_d_val(d_val), .sig_d_vbc(d_vbc), .sig_d_data(d_data),
    .sig_d_ready(d_ready),
    .sig_pkt_cnt(pkt_cnt), .sig_drop_cnt(drop_cnt), .sig_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Egress monitor: records accepted beats and counts changes on a stalled output.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (d_val !== 1'b1 || {d_sop, d_eop, d_vbc, d_data} !== prev_beat)) hold_viol++;
      if (d_val === 1'b1 && d_ready === 1'b1) rx_q.push_back({d_sop, d_eop, d_vbc, d_data});
      prev_stall = (d_val === 1'b1) && (d_ready === 1'b0);
      prev_beat  = {d_sop, d_eop, d_vbc, d_data};
    end
  end

  function automatic logic [255:0] mkd(input int unsigned p, input int unsigned b);
    logic [255:0] d;
    for (int unsigned k = 0; k < 8; k++) d[k*32 +: 32] = (p * 32'h0100_0193) ^ (b << 20) ^ k;
    return d;
  endfunction

  function automatic beat_t pk(input logic s, input logic e, input logic [7:0] c, input logic [255:0] d);
    return {s, e, c, d};
  endfunction

  function automatic logic [CW-1:0] cexp(input int unsigned n);
    return STATS ? CW'(n) : '0;
  endfunction

  task automatic drive(input logic s, input logic e, input logic v, input logic [7:0] c, input logic [255:0] d);
    i_sop = s; i_eop = e; i_val = v; i_vbc = c; i_data = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 8'd0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1; i_sop = 1'b0; i_eop = 1'b0; i_val = 1'b0; i_vbc = '0; i_data = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    rx_q.delete();
  endtask

  task automatic test_reset();
    d_ready = 1'b0;
    do_reset();
    vectors++; if (d_val !== 1'b0) begin miscompares++; $display("FAIL reset_d_val: got %0b expected 0", d_val); end
    vectors++; if ({d_sop, d_eop} !== 2'b00) begin miscompares++; $display("FAIL reset_d_sop_eop: got %b expected 00", {d_sop, d_eop}); end
    vectors++; if (d_vbc !== 8'd0) begin miscompares++; $display("FAIL reset_d_vbc: got %0d expected 0", d_vbc); end
    vectors++; if (d_data !== '0) begin miscompares++; $display("FAIL reset_d_data: got %h expected 0", d_data); end
    vectors++; if (buf_ready !== 1'b1) begin miscompares++; $display("FAIL reset_buf_ready: got %0b expected 1", buf_ready); end
    vectors++; if ({pkt_cnt, drop_cnt, err_cnt} !== '0) begin miscompares++; $display("FAIL reset_counters: got %h expected 0", {pkt_cnt, drop_cnt, err_cnt}); end
  endtask

  task automatic test_basic();
    beat_t exp_b[3];
    do_reset();
    d_ready = 1'b1;
    exp_b[0] = pk(1'b1, 1'b0, 8'd32, mkd(1, 0));
    exp_b[1] = pk(1'b0, 1'b0, 8'd32, mkd(1, 1));
    exp_b[2] = pk(1'b0, 1'b1, 8'd5,  mkd(1, 2));
    for (int unsigned b = 0; b < 3; b++) drive(exp_b[b][265], exp_b[b][264], 1'b1, exp_b[b][263:256], exp_b[b][255:0]);
    vectors++; if (d_val !== 1'b0) begin miscompares++; $display("FAIL basic_latency_n1: d_val got %0b expected 0", d_val); end
    idle(1);
    vectors++; if (d_val !== 1'b1 || {d_sop, d_eop, d_vbc, d_data} !== exp_b[0]) begin
      miscompares++; $display("FAIL basic_latency_n2: got val=%0b beat=%h expected val=1 beat=%h", d_val, {d_sop, d_eop, d_vbc, d_data}, exp_b[0]);
    end
    idle(4);
    vectors++; if (rx_q.size() != 3) begin miscompares++; $display("FAIL basic_count: got %0d beats expected 3", rx_q.size()); end
    else for (int unsigned b = 0; b < 3; b++) begin
      vectors++; if (rx_q[b] !== exp_b[b]) begin miscompares++; $display("FAIL basic_beat%0d: got %h expected %h", b, rx_q[b], exp_b[b]); end
    end
    vectors++; if (pkt_cnt !== cexp(1)) begin miscompares++; $display("FAIL basic_pkt_cnt: got %0d expected %0d", pkt_cnt, cexp(1)); end
  endtask

  task automatic test_overflow();
    beat_t exp_b[2];
    beat_t single;
    do_reset();
    d_ready = 1'b0;
    for (int unsigned b = 0; b < 16; b++) drive(b == 0, 1'b0, 1'b1, 8'd32, mkd(2, b));
    vectors++; if (buf_ready !== 1'b0) begin miscompares++; $display("FAIL ovf_full_ready: got %0b expected 0", buf_ready); end
    drive(1'b0, 1'b1, 1'b1, 8'd32, mkd(2, 16));
    vectors++; if (buf_ready !== 1'b1) begin miscompares++; $display("FAIL ovf_after_drop_ready: got %0b expected 1", buf_ready); end
    vectors++; if (drop_cnt !== cexp(1)) begin miscompares++; $display("FAIL ovf_drop_cnt: got %0d expected %0d", drop_cnt, cexp(1)); end
    idle(3);
    vectors++; if (d_val !== 1'b0) begin miscompares++; $display("FAIL ovf_no_output: d_val got %0b expected 0", d_val); end
    exp_b[0] = pk(1'b1, 1'b0, 8'd32, mkd(3, 0));
    exp_b[1] = pk(1'b0, 1'b1, 8'd20, mkd(3, 1));
    drive(1'b1, 1'b0, 1'b1, 8'd32, mkd(3, 0));
    drive(1'b0, 1'b1, 1'b1, 8'd20, mkd(3, 1));
    idle(1);
    vectors++; if (d_val !== 1'b1 || {d_sop, d_eop, d_vbc, d_data} !== exp_b[0]) begin
      miscompares++; $display("FAIL ovf_next_head: got val=%0b beat=%h expected val=1 beat=%h", d_val, {d_sop, d_eop, d_vbc, d_data}, exp_b[0]);
    end
    d_ready = 1'b1;
    idle(4);
    vectors++; if (rx_q.size() != 2) begin miscompares++; $display("FAIL ovf_next_count: got %0d beats expected 2", rx_q.size()); end
    else for (int unsigned b = 0; b < 2; b++) begin
      vectors++; if (rx_q[b] !== exp_b[b]) begin miscompares++; $display("FAIL ovf_next_beat%0d: got %h expected %h", b, rx_q[b], exp_b[b]); end
    end
    // Overflow on a non-eop beat: the remainder is swallowed until eop.
    rx_q.delete();
    d_ready = 1'b0;
    for (int unsigned b = 0; b < 17; b++) drive(b == 0, 1'b0, 1'b1, 8'd32, mkd(4, b));
    drive(1'b0, 1'b0, 1'b1, 8'd32, mkd(4, 17));
    drive(1'b0, 1'b1, 1'b1, 8'd32, mkd(4, 18));
    idle(2);
    vectors++; if (d_val !== 1'b0) begin miscompares++; $display("FAIL discard_no_output: d_val got %0b expected 0", d_val); end
    vectors++; if (drop_cnt !== cexp(2) || err_cnt !== cexp(0)) begin
      miscompares++; $display("FAIL discard_counts: drop=%0d err=%0d expected drop=%0d err=%0d", drop_cnt, err_cnt, cexp(2), cexp(0));
    end
    single = pk(1'b1, 1'b1, 8'd16, mkd(5, 0));
    drive(1'b1, 1'b1, 1'b1, 8'd16, mkd(5, 0));
    d_ready = 1'b1;
    idle(4);
    vectors++; if (rx_q.size() != 1 || rx_q[0] !== single) begin
      miscompares++; $display("FAIL discard_next_pkt: got %0d beats first=%h expected 1 beat %h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : '0, single);
    end
  endtask

  task automatic test_framing();
    beat_t exp_b[2];
    do_reset();
    d_ready = 1'b1;
    exp_b[0] = pk(1'b1, 1'b0, 8'd32, mkd(7, 0));
    exp_b[1] = pk(1'b0, 1'b1, 8'd10, mkd(7, 1));
    drive(1'b1, 1'b0, 1'b1, 8'd32, mkd(6, 0));
    drive(1'b1, 1'b0, 1'b1, 8'd32, mkd(7, 0));
    drive(1'b0, 1'b1, 1'b1, 8'd10, mkd(7, 1));
    vectors++; if (err_cnt !== cexp(1)) begin miscompares++; $display("FAIL frame_abort_err: got %0d expected %0d", err_cnt, cexp(1)); end
    idle(4);
    vectors++; if (rx_q.size() != 2) begin miscompares++; $display("FAIL frame_second_count: got %0d beats expected 2", rx_q.size()); end
    else for (int unsigned b = 0; b < 2; b++) begin
      vectors++; if (rx_q[b] !== exp_b[b]) begin miscompares++; $display("FAIL frame_second_beat%0d: got %h expected %h", b, rx_q[b], exp_b[b]); end
    end
    rx_q.delete();
    drive(1'b0, 1'b0, 1'b1, 8'd32, mkd(8, 0));
    idle(4);
    vectors++; if (err_cnt !== cexp(2)) begin miscompares++; $display("FAIL frame_stray_err: got %0d expected %0d", err_cnt, cexp(2)); end
    vectors++; if (rx_q.size() != 0 || d_val !== 1'b0) begin miscompares++; $display("FAIL frame_stray_stored: got %0d beats val=%0b expected 0 beats val=0", rx_q.size(), d_val); end
    vectors++; if (pkt_cnt !== cexp(1)) begin miscompares++; $display("FAIL frame_pkt_cnt: got %0d expected %0d", pkt_cnt, cexp(1)); end
  endtask

  task automatic test_bad_vbc();
    beat_t single;
    do_reset();
    d_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 8'd32, mkd(9, 0));
    drive(1'b0, 1'b0, 1'b1, 8'd40, mkd(9, 1));
    drive(1'b0, 1'b1, 1'b1, 8'd32, mkd(9, 2));
    vectors++; if (drop_cnt !== cexp(1)) begin miscompares++; $display("FAIL badvbc_mid_drop: got %0d expected %0d", drop_cnt, cexp(1)); end
    drive(1'b1, 1'b1, 1'b1, 8'd0, mkd(10, 0));
    vectors++; if (drop_cnt !== cexp(2)) begin miscompares++; $display("FAIL badvbc_zero_drop: got %0d expected %0d", drop_cnt, cexp(2)); end
    drive(1'b1, 1'b0, 1'b1, 8'd31, mkd(11, 0));
    drive(1'b0, 1'b1, 1'b1, 8'd32, mkd(11, 1));
    vectors++; if (drop_cnt !== cexp(3)) begin miscompares++; $display("FAIL badvbc_short_noeop_drop: got %0d expected %0d", drop_cnt, cexp(3)); end
    single = pk(1'b1, 1'b1, 8'd1, mkd(12, 0));
    drive(1'b1, 1'b1, 1'b1, 8'd1, mkd(12, 0));
    idle(4);
    vectors++; if (rx_q.size() != 1 || rx_q[0] !== single) begin
      miscompares++; $display("FAIL badvbc_only_good: got %0d beats first=%h expected 1 beat %h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : '0, single);
    end
    vectors++; if (pkt_cnt !== cexp(1) || err_cnt !== cexp(0)) begin
      miscompares++; $display("FAIL badvbc_counts: pkt=%0d err=%0d expected pkt=%0d err=%0d", pkt_cnt, err_cnt, cexp(1), cexp(0));
    end
  endtask

  task automatic test_backpressure_wrap();
    beat_t exp_q[$];
    bit    done = 1'b0;
    int unsigned stalls = 0;
    int unsigned wait_cyc = 0;
    do_reset();
    hold_viol = 0;
    fork
      begin
        for (int unsigned p = 0; p < 200; p++) begin
          int unsigned len = $urandom_range(1, 8);
          for (int unsigned b = 0; b < len; b++) begin
            logic       s = (b == 0);
            logic       e = (b == len - 1);
            logic [7:0] c = e ? 8'($urandom_range(1, 32)) : 8'd32;
            int unsigned g = 0;
            while (buf_ready !== 1'b1 && g < 1000) begin idle(1); g++; end
            if (g >= 1000) stalls++;
            drive(s, e, 1'b1, c, mkd(100 + p, b));
            exp_q.push_back(pk(s, e, c, mkd(100 + p, b)));
          end
        end
        while (rx_q.size() < exp_q.size() && wait_cyc < 5000) begin idle(1); wait_cyc++; end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          d_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    d_ready = 1'b1;
    idle(2);
    vectors++; if (stalls != 0) begin miscompares++; $display("FAIL bp_ingress_stall: got %0d timeouts expected 0", stalls); end
    vectors++; if (rx_q.size() != exp_q.size()) begin miscompares++; $display("FAIL bp_beat_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    else for (int unsigned k = 0; k < exp_q.size(); k++) begin
      vectors++;
      if (rx_q[k] !== exp_q[k]) begin
        miscompares++; $display("FAIL bp_beat%0d: got %h expected %h", k, rx_q[k], exp_q[k]);
        break;
      end
    end
    vectors++; if (hold_viol != 0) begin miscompares++; $display("FAIL bp_hold_stable: got %0d violations expected 0", hold_viol); end
    vectors++; if (pkt_cnt !== cexp(200) || drop_cnt !== cexp(0) || err_cnt !== cexp(0)) begin
      miscompares++; $display("FAIL bp_counters: pkt=%0d drop=%0d err=%0d expected %0d/%0d/%0d", pkt_cnt, drop_cnt, err_cnt, cexp(200), cexp(0), cexp(0));
    end
  endtask

  task automatic test_reset_mid();
    beat_t exp_b[2];
    do_reset();
    d_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 8'd12, mkd(20, 0));
    idle(2);
    vectors++; if (d_val !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_val: got %0b expected 1", d_val); end
    drive(1'b1, 1'b0, 1'b1, 8'd32, mkd(21, 0));
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 8'd32, mkd(21, 1));
    rst = 1'b0;
    i_val = 1'b0;
    vectors++; if ({d_val, d_sop, d_eop} !== 3'b000 || d_vbc !== 8'd0 || d_data !== '0) begin
      miscompares++; $display("FAIL rstmid_outputs: got val=%0b sop=%0b eop=%0b vbc=%0d data=%h expected all 0", d_val, d_sop, d_eop, d_vbc, d_data);
    end
    vectors++; if (buf_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_buf_ready: got %0b expected 1", buf_ready); end
    rx_q.delete();
    d_ready = 1'b1;
    exp_b[0] = pk(1'b1, 1'b0, 8'd32, mkd(22, 0));
    exp_b[1] = pk(1'b0, 1'b1, 8'd3,  mkd(22, 1));
    drive(1'b1, 1'b0, 1'b1, 8'd32, mkd(22, 0));
    drive(1'b0, 1'b1, 1'b1, 8'd3,  mkd(22, 1));
    idle(5);
    vectors++; if (rx_q.size() != 2) begin miscompares++; $display("FAIL rstmid_next_count: got %0d beats expected 2", rx_q.size()); end
    else for (int unsigned b = 0; b < 2; b++) begin
      vectors++; if (rx_q[b] !== exp_b[b]) begin miscompares++; $display("FAIL rstmid_next_beat%0d: got %h expected %h", b, rx_q[b], exp_b[b]); end
    end
    vectors++; if (pkt_cnt !== cexp(1)) begin miscompares++; $display("FAIL rstmid_pkt_cnt: got %0d expected %0d", pkt_cnt, cexp(1)); end
  endtask

  initial begin
    rst = 1'b1; i_sop = 1'b0; i_eop = 1'b0; i_val = 1'b0; i_vbc = '0; i_data = '0; d_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_framing();
    test_bad_vbc();
    test_backpressure_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/c3po_egress_buf.md
# c3po_egress_buf

Packet store-and-forward buffer directly downstream of the c3po core. Consumes the core's 32-byte beat stream (sop/eop/val/vbc/data) and holds each packet until its eop beat is written. Only then does it release the packet to the egress consumer under a valid/ready handshake. Drops overflowing or malformed packets and keeps saturating packet, drop and error counters.

## Interface
- DEPTH_P, 16, beat entries in the buffer; power of two, ≥4
- CNT_SIZE_P, 8, statistics counter width
- sig_clock  in  1  clock
- sig_reset  in  1  synchronous reset, active high
- sig_i_sop  in  1  first beat of packet
- sig_i_eop  in  1  last beat of packet
- sig_i_val  in  1  beat valid
- sig_i_vbc  in  8  valid byte count of beat, 1..32
- sig_i_data  in  256  beat data, byte 0 in [7:0]
- sig_buf_ready  out  1  buffer can accept a beat this cycle
- sig_d_sop  out  1  egress first beat
- sig_d_eop  out  1  egress last beat
- sig_d_val  out  1  egress beat valid
- sig_d_vbc  out  8  egress valid byte count
- sig_d_data  out  256  egress beat data
- sig_d_ready  in  1  egress consumer accepts beat
- sig_pkt_cnt  out  CNT_SIZE_P  packets committed
- sig_drop_cnt  out  CNT_SIZE_P  packets dropped (overflow or bad vbc)
- sig_err_cnt  out  CNT_SIZE_P  framing errors

## Operation
- Storage: DEPTH_P × 266-bit array of {sop, eop, vbc, data}.
- Pointers: wr_ptr, commit_ptr and rd_ptr, each log2(DEPTH_P)+1 bits and wrapping naturally.
- full = (wr_ptr − rd_ptr == DEPTH_P). sig_buf_ready = !full, or state is DISCARD.
- Input beat accepted when sig_i_val is high; stored only if !full.
- Write FSM states: IDLE, PKT, DISCARD.
- IDLE, val & sop: store beat and go to PKT. If eop is also set, commit at once and stay in IDLE.
- IDLE, val & !sop: beat discarded, err_cnt+1, stay in IDLE.
- PKT, val & sop: abort the current packet (wr_ptr ← commit_ptr), err_cnt+1, then treat the beat as a new sop in the same cycle.
- PKT, val & eop & no bad flag: commit_ptr ← wr_ptr+1, pkt_cnt+1, go to IDLE.
- Bad flag: set when any beat has vbc==0, vbc>32, or vbc≠32 without eop.
- PKT, eop with bad flag set: wr_ptr ← commit_ptr, drop_cnt+1, go to IDLE.
- PKT, val while full: wr_ptr ← commit_ptr, drop_cnt+1. Go to DISCARD, or to IDLE if that beat has eop.
- The full rule also covers packets longer than DEPTH_P beats, so there is no deadlock.
- DISCARD: all beats ignored until an eop beat, then IDLE. A sop seen in DISCARD counts err_cnt+1 and is handled as a sop from IDLE.
- Read side: the output register loads entry[rd_ptr] when rd_ptr≠commit_ptr and (!sig_d_val or sig_d_ready). rd_ptr increments on each load. The read side never passes commit_ptr.
- Counters saturate at all-ones.
- Write-side and read-side updates in the same cycle are independent. full is evaluated on pre-edge occupancy, so a pop in the same cycle does not unblock a write at full.

## Timing
- Reset: all pointers 0, state IDLE, bad flag 0, counters 0.
- Reset: sig_d_sop/eop/val 0, sig_d_vbc 0, sig_d_data 0. sig_buf_ready 1 on the first cycle after reset.
- Reset mid-packet: the partial packet and all buffered packets are lost.
- Latency: eop beat presented in cycle N → commit visible in N+1 → sig_d_val high in N+2, with the first beat of that packet if the buffer was otherwise empty.
- Throughput: one beat per cycle on each side.
- Handshake: while sig_d_val=1 and sig_d_ready=0, all sig_d_* hold stable.
- sig_d_val never drops between sop and eop of a committed packet if sig_d_ready stays high.
- sig_buf_ready is combinational from registered state only; it has no path from sig_i_*.

## Configuration
- C3PO_EGRESS_STATS_EN defined: the three counters are implemented as above.
- C3PO_EGRESS_STATS_EN undefined: counters are not implemented and sig_pkt_cnt/sig_drop_cnt/sig_err_cnt are tied to 0. Datapath behaviour is identical.

## Test plan
- **Basic packet:** 3-beat packet (vbc 32, 32, 5), sig_d_ready=1 → egress beats identical, sig_d_val rises 2 cycles after the eop beat, pkt_cnt=1.
- **Overflow:** DEPTH_P=16 and sig_d_ready=0 throughout; 17-beat packet driven ignoring ready → beat 17 dropped, packet discarded, drop_cnt=1, sig_d_val stays 0. A following 2-beat packet is committed.
- **Framing errors:** sop at beat 2 of an open packet → first packet aborted, err_cnt=1, second packet delivered intact. Stray val without sop in IDLE → err_cnt=2, nothing stored.
- **Bad vbc:** vbc=40 on a middle beat → whole packet dropped at eop, drop_cnt=1. vbc=0 on a single-beat sop+eop → drop_cnt=2.
- **Backpressure and wrap:** random sig_d_ready at 50% with 200 packets of 1–8 beats → output matches scoreboard in order, held beats stable, pointers wrap cleanly. Repeat with the macro undefined → counters read 0.
- **Reset mid-packet:** assert sig_reset during beat 2 of 4 → all outputs 0 next cycle, sig_buf_ready=1. A subsequent packet is delivered correctly.
